// File: rtl/k16_bus_fabric.sv
// k16_bus_fabric: single-master 16-bit address decoder with per-slave wait states.
// Define K16_BUS_ERR_EN to build the unmapped-access error capture (bus_err/err_addr/err_count).
module k16_bus_fabric #(
  parameter int                        NUM_SLAVES = 3,
  parameter logic [16*NUM_SLAVES-1:0]  SLAVE_BASE = {16'hFFF8, 16'h8000, 16'h0000},
  parameter logic [16*NUM_SLAVES-1:0]  SLAVE_MASK = {16'hFFF8, 16'hF800, 16'hFC00},
  parameter logic [4*NUM_SLAVES-1:0]   SLAVE_WAIT = {4'd0, 4'd0, 4'd0}
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cpu_req,
  input  logic [15:0]                  cpu_addr,
  input  logic [15:0]                  cpu_dout,
  input  logic                         cpu_write,
  input  logic                         hold,
  output logic                         cpu_ack,
  output logic [15:0]                  cpu_din,
  output logic [15:0]                  s_addr,
  output logic [15:0]                  s_wdata,
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic [NUM_SLAVES-1:0]        s_we,
  input  logic [16*NUM_SLAVES-1:0]     s_rdata,
  output logic                         bus_err,
  output logic [15:0]                  err_addr,
  output logic [7:0]                   err_count,
  output logic [1:0]                   dbg_state_o
);

  // Handshake: cpu_req is held high until the one-cycle cpu_ack pulse; a request is
  // taken only in IDLE with hold=0, and all cpu_* inputs are ignored until IDLE again.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        write_q;
  logic        mapped_q;
  logic [2:0]  idx_q;
  logic [3:0]  cnt_q;
  logic        first_q;

  logic        hit;
  logic [2:0]  hit_idx;
  logic [15:0] hit_off;
  logic [3:0]  hit_wait;
  logic        accept;

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_off  = '0;
    hit_wait = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if ((cpu_addr & SLAVE_MASK[16*k +: 16]) == SLAVE_BASE[16*k +: 16]) begin
        hit      = 1'b1;
        hit_idx  = 3'(k);
        hit_off  = cpu_addr & ~SLAVE_MASK[16*k +: 16];
        hit_wait = SLAVE_WAIT[4*k +: 4];
      end
    end
  end

  assign accept = (state_q == IDLE) && cpu_req && !hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      mapped_q <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      first_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q   <= hit ? hit_off : 16'h0000;
            wdata_q  <= cpu_dout;
            write_q  <= cpu_write;
            mapped_q <= hit;
            idx_q    <= hit_idx;
            cnt_q    <= hit_wait;
            first_q  <= 1'b1;
            state_q  <= hit ? ACCESS : RESP;
          end
        end
        ACCESS: begin
          first_q <= 1'b0;
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [NUM_SLAVES-1:0] sel_vec;
  logic [15:0]           rdata_sel;

  always_comb begin
    sel_vec   = '0;
    rdata_sel = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx_q == 3'(k)) begin
        sel_vec[k] = 1'b1;
        rdata_sel  = s_rdata[16*k +: 16];
      end
    end
  end

  // Slave outputs decode from registered state, so an async reset clears them at once.
  assign s_sel       = ((state_q != IDLE) && mapped_q) ? sel_vec : '0;
  assign s_we        = ((state_q == ACCESS) && first_q && write_q) ? sel_vec : '0;
  assign s_addr      = addr_q;
  assign s_wdata     = wdata_q;
  assign cpu_ack     = (state_q == RESP);
  assign cpu_din     = ((state_q == RESP) && mapped_q && !write_q) ? rdata_sel : 16'h0000;
  assign dbg_state_o = state_q;

`ifdef K16_BUS_ERR_EN
  logic [15:0] err_addr_q;
  logic [7:0]  err_count_q;
  logic [7:0]  err_count_d;

  assign err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else if (accept && !hit) begin
      err_addr_q  <= cpu_addr;
      err_count_q <= err_count_d;
    end
  end

  assign bus_err   = (state_q == RESP) && !mapped_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;
`else
  assign bus_err   = 1'b0;
  assign err_addr  = 16'h0000;
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_k16_bus_fabric.sv
// Scoreboard bench for k16_bus_fabric: a driver pushes expected responses, a monitor checks them on cpu_ack.
// Four-slave map: slave 3 (0x0000/F000) overlaps slave 0 so the lowest-index rule is exercised.
module tb_k16_bus_fabric;

  localparam int          NS     = 4;
  localparam logic [63:0] BASE_P = {16'h0000, 16'hFFF8, 16'h8000, 16'h0000};
  localparam logic [63:0] MASK_P = {16'hF000, 16'hFFF8, 16'hF800, 16'hFC00};
  localparam logic [15:0] WAIT_P = {4'd1, 4'd1, 4'd3, 4'd0};

  logic          clk;
  logic          reset;
  logic          cpu_req;
  logic [15:0]   cpu_addr;
  logic [15:0]   cpu_dout;
  logic          cpu_write;
  logic          hold;
  logic          cpu_ack;
  logic [15:0]   cpu_din;
  logic [15:0]   s_addr;
  logic [15:0]   s_wdata;
  logic [NS-1:0] s_sel;
  logic [NS-1:0] s_we;
  logic [63:0]   s_rdata;
  logic          bus_err;
  logic [15:0]   err_addr;
  logic [7:0]    err_count;
  logic [1:0]    dbg_state_o;

  k16_bus_fabric #(
    .NUM_SLAVES (NS),
    .SLAVE_BASE (BASE_P),
    .SLAVE_MASK (MASK_P),
    .SLAVE_WAIT (WAIT_P)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_addr    (cpu_addr),
    .cpu_dout    (cpu_dout),
    .cpu_write   (cpu_write),
    .hold        (hold),
    .cpu_ack     (cpu_ack),
    .cpu_din     (cpu_din),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_sel       (s_sel),
    .s_we        (s_we),
    .s_rdata     (s_rdata),
    .bus_err     (bus_err),
    .err_addr    (err_addr),
    .err_count   (err_count),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- slave memories (1-cycle synchronous read) ----------------
  function automatic logic [15:0] init_val(input int k, input int a);
    if (k == 0 && a == 5) return 16'h1234;
    return 16'((k * 16'h1111) ^ (a * 16'h0025) ^ 16'h5A00);
  endfunction

  logic [15:0] slave_mem [4][4096];
  bit          slave_vld [4][4096];
  logic [15:0] slv_rd    [4];

  always @(posedge clk) begin
    for (int k = 0; k < NS; k++) begin
      if (s_sel[k]) begin
        if (s_we[k]) begin
          slave_mem[k][s_addr[11:0]] <= s_wdata;
          slave_vld[k][s_addr[11:0]] <= 1'b1;
        end
        slv_rd[k] <= slave_vld[k][s_addr[11:0]] ? slave_mem[k][s_addr[11:0]]
                                                 : init_val(k, int'(s_addr[11:0]));
      end
    end
  end
  assign s_rdata = {slv_rd[3], slv_rd[2], slv_rd[1], slv_rd[0]};

  // ---------------- reference model ----------------
  typedef struct {
    int          ack_edge;
    logic [15:0] din;
    logic [3:0]  sel;
    logic [3:0]  we;
    int          sel_cyc;
    int          we_cyc;
    logic [15:0] saddr;
    logic [15:0] wdata;
    logic        wr;
    logic        mapped;
    logic        berr;
    logic [15:0] eaddr;
    logic [7:0]  ecnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ref_mem [4][4096];
  logic [7:0]  ref_ecnt  = 8'h00;
  logic [15:0] ref_eaddr = 16'h0000;

  function automatic int ref_decode(input logic [15:0] a);
    for (int k = 0; k < NS; k++)
      if ((a & MASK_P[16*k +: 16]) == BASE_P[16*k +: 16]) return k;
    return -1;
  endfunction

  // ---------------- scoreboard bookkeeping ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t       mon_e;
  int         sel_cyc = 0;
  int         we_cyc  = 0;
  logic [3:0] sel_or  = '0;
  logic [3:0] we_or   = '0;

  always @(negedge clk) begin
    if (!reset) begin
      sel_cyc = 0; we_cyc = 0; sel_or = '0; we_or = '0;
    end else begin
      if (s_sel != '0) begin sel_cyc++; sel_or |= s_sel; end
      if (s_we != '0)  begin we_cyc++;  we_or  |= s_we;  end
      if (cpu_ack) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_ack: cpu_ack with no pending access (t=%0t)", $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ack_latency", 64'(cyc),     64'(mon_e.ack_edge));
          chk("cpu_din",     64'(cpu_din), 64'(mon_e.din));
          chk("sel_value",   64'(sel_or),  64'(mon_e.sel));
          chk("sel_cycles",  64'(sel_cyc), 64'(mon_e.sel_cyc));
          chk("we_value",    64'(we_or),   64'(mon_e.we));
          chk("we_cycles",   64'(we_cyc),  64'(mon_e.we_cyc));
          if (mon_e.mapped) chk("s_addr", 64'(s_addr), 64'(mon_e.saddr));
          if (mon_e.mapped && mon_e.wr) chk("s_wdata", 64'(s_wdata), 64'(mon_e.wdata));
          chk("bus_err",   64'(bus_err),   64'(mon_e.berr));
          chk("err_addr",  64'(err_addr),  64'(mon_e.eaddr));
          chk("err_count", 64'(err_count), 64'(mon_e.ecnt));
        end
        sel_cyc = 0; we_cyc = 0; sel_or = '0; we_or = '0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge with the DUT idle; returns just after the edge that ends RESP.
  task automatic run_txn(input logic [15:0] addr, input logic [15:0] data,
                         input logic wr, input int hold_cyc);
    exp_t e;
    int   k;
    int   w;
    int   n;
    bit   got;
    k = ref_decode(addr);
    cpu_addr = addr; cpu_dout = data; cpu_write = wr; cpu_req = 1'b1;
    hold = (hold_cyc > 0);
    for (int i = 0; i < hold_cyc; i++) begin
      @(posedge clk); #1;
      chk("hold_blocks", {60'd0, s_sel}, 64'd0);
    end
    hold = 1'b0;
    @(posedge clk); #1;
    n = cyc;
    e.wr = wr;
    e.wdata = data;
    if (k >= 0) begin
      w = int'(WAIT_P[4*k +: 4]);
      e.mapped   = 1'b1;
      e.ack_edge = n + w + 1;
      e.sel      = 4'(1 << k);
      e.we       = wr ? e.sel : 4'd0;
      e.sel_cyc  = w + 2;
      e.we_cyc   = wr ? 1 : 0;
      e.saddr    = addr & ~MASK_P[16*k +: 16];
      e.din      = wr ? 16'h0000 : ref_mem[k][e.saddr[11:0]];
      if (wr) ref_mem[k][e.saddr[11:0]] = data;
    end else begin
      e.mapped   = 1'b0;
      e.ack_edge = n;
      e.sel      = 4'd0;
      e.we       = 4'd0;
      e.sel_cyc  = 0;
      e.we_cyc   = 0;
      e.saddr    = 16'h0000;
      e.din      = 16'h0000;
`ifdef K16_BUS_ERR_EN
      ref_eaddr = addr;
      if (ref_ecnt != 8'hFF) ref_ecnt = ref_ecnt + 8'd1;
`endif
    end
`ifdef K16_BUS_ERR_EN
    e.berr  = (k < 0);
    e.eaddr = ref_eaddr;
    e.ecnt  = ref_ecnt;
`else
    e.berr  = 1'b0;
    e.eaddr = 16'h0000;
    e.ecnt  = 8'h00;
`endif
    exp_q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (cpu_ack) got = 1'b1;
      else begin
        @(posedge clk); #1;
        cpu_addr = 16'($urandom); cpu_dout = 16'($urandom);
        cpu_write = 1'($urandom); hold = 1'($urandom);
      end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL ack_timeout: no cpu_ack for addr %h", addr);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; hold = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic reset_mid_access();
    cpu_addr = 16'h8777; cpu_dout = 16'h5EED; cpu_write = 1'b1; cpu_req = 1'b1; hold = 1'b0;
    @(posedge clk); #1;
    ref_mem[1][12'h777] = 16'h5EED;
    @(posedge clk); #2;
    chk("in_second_access_sel", {60'd0, s_sel}, 64'h2);
    reset = 1'b0; cpu_req = 1'b0;
    #1;
    chk("abort_outputs_a", {15'd0, cpu_ack, cpu_din, s_addr, s_wdata}, 64'd0);
    chk("abort_outputs_b", {30'd0, s_sel, s_we, bus_err, err_addr, err_count, dbg_state_o}, 64'd0);
    ref_ecnt = 8'h00; ref_eaddr = 16'h0000;
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 4))
      0:       return 16'h0000 + 16'($urandom_range(0, 15));
      1:       return 16'h8000 + 16'($urandom_range(0, 15));
      2:       return 16'hFFF8 + 16'($urandom_range(0, 7));
      3:       return 16'h0400 + 16'($urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < 4; k++)
      for (int a = 0; a < 4096; a++) ref_mem[k][a] = init_val(k, a);
    reset = 1'b0; cpu_req = 1'b0; cpu_addr = '0; cpu_dout = '0; cpu_write = 1'b0; hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs_a", {15'd0, cpu_ack, cpu_din, s_addr, s_wdata}, 64'd0);
    chk("reset_outputs_b", {30'd0, s_sel, s_we, bus_err, err_addr, err_count, dbg_state_o}, 64'd0);
    #1 reset = 1'b1;

    run_txn(16'h0005, 16'h0000, 1'b0, 0);
    run_txn(16'h8123, 16'hABCD, 1'b1, 0);
    run_txn(16'h8123, 16'h0000, 1'b0, 0);
    run_txn(16'h4000, 16'h0000, 1'b0, 0);
    run_txn(16'hFFF9, 16'h0000, 1'b0, 10);
    run_txn(16'h0010, 16'h0000, 1'b0, 0);
    run_txn(16'h0800, 16'h0000, 1'b0, 0);
    run_txn(16'h0010, 16'h7777, 1'b1, 1);
    run_txn(16'h0010, 16'h0000, 1'b0, 0);

    for (int i = 0; i < 300; i++)
      run_txn(16'h4000 | 16'($urandom_range(0, 16'h3FFF)), 16'($urandom), 1'($urandom), 0);

    reset_mid_access();
    run_txn(16'h8777, 16'h0000, 1'b0, 0);
    run_txn(16'h9000, 16'h0000, 1'b1, 0);

    for (int i = 0; i < 200; i++) begin
      run_txn(rand_addr(), 16'($urandom), 1'($urandom), $urandom_range(0, 2));
      idle_gap($urandom_range(0, 2));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
